simplerisc_reg_file: RTL and testbench
======================================

# simplerisc_reg_file

Architectural register file for the SimpleRisc core: the consuming end of the write-back interface (write address, write data, write enable) and the producer of source operands for execute. Holds 16 x 32-bit registers (r15 = ra). Writes commit on the clock edge. Two read ports are sampled into a registered operand stage with stall and flush control.

## Interface
- NUM_REGS, 16, number of architectural registers (fixed; r15 is ra)
- DATA_W, 32, register width
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- reg1  input  4  write address from write-back
- writeData  input  32  write data from write-back
- writeEnable  input  1  write strobe from write-back
- rs1_addr  input  4  source operand 1 address from decode
- rs2_addr  input  4  source operand 2 address from decode
- rd_req  input  1  decode presents a valid read this cycle
- stall  input  1  hold the operand stage
- flush  input  1  invalidate the operand stage
- op1  output  32  registered operand 1
- op2  output  32  registered operand 2
- op_valid  output  1  op1/op2 hold a valid issued read
- ra_value  output  32  current r15 contents (combinational from array), for ret

## Operation
- Write: at rising edge with writeEnable=1 and rst=0, regs[reg1] <= writeData. All 16 registers are writable; r0 is not hardwired to zero.
- Read: the operand stage updates when stall=0: op1 <= value(rs1_addr), op2 <= value(rs2_addr), op_valid <= rd_req.
- value(a) = regs[a], or writeData when bypass is compiled in and writeEnable=1 and reg1==a.
- stall=1, flush=0: op1, op2 and op_valid hold. The register array still accepts writes.
- flush=1: op_valid <= 0 regardless of stall; op1/op2 may load or hold (don't-care, but must not be X).
- rd_req=0 with stall=0: op_valid <= 0; op1/op2 still load (value irrelevant).
- ra_value always reflects regs[15] as of the last edge (no bypass on this path).

## Timing
- Write latency: data visible in the array one edge after writeEnable.
- Read latency: one cycle; addresses at cycle N give op1/op2/op_valid valid after edge N+1.
- Same-cycle write and read of the same address: with bypass, the new data; without bypass, the old data.
- Reset (rst=1 at an edge): all 16 registers <= 0, op1 <= 0, op2 <= 0, op_valid <= 0. Reset dominates writeEnable, stall and flush. A reset in the middle of a stall drops the held operand.
- Two reads of the same address in one cycle: both ports return the same value.

## Configuration
- SIMPLERISC_RF_BYPASS_EN defined: write-to-read forwarding as above. This closes the one-cycle write-back to decode hazard.
- Not defined: reads return the array contents only. The pipeline controller must stall one extra cycle on a RAW hazard with write-back.

## Structure
- Shared package simplerisc_pkg:
  - REG_ADDR_W=4, DATA_W=32, NUM_REGS=16, RA_INDEX=4'd15
  - typedef reg_addr_t (4 bit), typedef word_t (32 bit)
- Sub-module reg_array: 16 x 32 storage with synchronous reset, one write port and three asynchronous read ports (rs1, rs2, r15).
- The top level adds the bypass muxes and the operand stage.

## Test plan
- Reset: hold rst 1 cycle, then read r0..r15 -> all 0, op_valid=0, ra_value=0.
- Write then read: write r3=0xDEADBEEF at cycle 1; read rs1=3, rs2=15 with rd_req at cycle 2 -> after edge 3, op1=0xDEADBEEF, op2=0, op_valid=1.
- Same-cycle hazard: write r5=0x12345678 while reading rs1=5 (r5 previously 0x11) -> op1=0x12345678 with bypass, 0x11 without. ra_value is unaffected.
- Stall: load op1=0xA, then stall=1 for 3 cycles while writing the source register to 0xB -> op1 stays 0xA and op_valid stays 1. On release with rd_req=1 the re-read returns 0xB.
- Flush vs stall: stall=1 and flush=1 together -> op_valid=0 next cycle. A write in the same cycle still commits.
- Reset mid-operation: write r15=0x40 while rst=1 -> r15=0 and ra_value=0. A write the next cycle gives ra_value=0x40 one cycle later.

Source files
------------

// File: rtl/simplerisc_pkg.sv
// Shared definitions for the SimpleRisc register file slice.
// Configuration macro used by the register file top: SIMPLERISC_RF_BYPASS_EN.
package simplerisc_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  // r15 doubles as the return-address register
  localparam reg_addr_t RA_INDEX = 4'd15;

endpackage

// File: rtl/simplerisc_reg_file_reg_array.sv
// Storage for the 16 architectural registers: synchronous reset, one write
// port and three asynchronous read ports (two operands plus the ra tap).
module reg_array
  import simplerisc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  word_t     wdata_i,
  input  reg_addr_t raddr1_i,
  input  reg_addr_t raddr2_i,
  output word_t     rdata1_o,
  output word_t     rdata2_o,
  output word_t     ra_o
);

  word_t regs_q [NUM_REGS];

  // Clear every register on reset, otherwise commit the write-back on the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];
  assign ra_o     = regs_q[RA_INDEX];

endmodule

// File: rtl/simplerisc_reg_file.sv
// SimpleRisc architectural register file with a registered operand stage.
// Define SIMPLERISC_RF_BYPASS_EN to forward same-cycle write-back data into
// the operand reads; without it the array contents are returned as-is and the
// pipeline controller has to stall an extra cycle on the write-back hazard.
module simplerisc_reg_file
  import simplerisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        reg1,
  input  logic [DATA_W-1:0] writeData,
  input  logic              writeEnable,
  input  logic [3:0]        rs1_addr,
  input  logic [3:0]        rs2_addr,
  input  logic              rd_req,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic              op_valid,
  output logic [DATA_W-1:0] ra_value
);

  word_t arrRs1;
  word_t arrRs2;
  word_t value1;
  word_t value2;

  word_t op1_q, op1_d;
  word_t op2_q, op2_d;
  logic  opValid_q, opValid_d;

  reg_array uArray (
    .clk      (clk),
    .rst      (rst),
    .we_i     (writeEnable),
    .waddr_i  (reg1),
    .wdata_i  (writeData),
    .raddr1_i (rs1_addr),
    .raddr2_i (rs2_addr),
    .rdata1_o (arrRs1),
    .rdata2_o (arrRs2),
    .ra_o     (ra_value)
  );

`ifdef SIMPLERISC_RF_BYPASS_EN
  // Forward the in-flight write-back value when it targets a source register
  always_comb begin
    value1 = arrRs1;
    value2 = arrRs2;
    if (writeEnable && (reg1 == rs1_addr)) value1 = writeData;
    if (writeEnable && (reg1 == rs2_addr)) value2 = writeData;
  end
`else
  // No forwarding: operands come straight from the array
  always_comb begin
    value1 = arrRs1;
    value2 = arrRs2;
  end
`endif

  // Operand stage next state: load when not stalled, flush always kills valid
  always_comb begin
    op1_d     = op1_q;
    op2_d     = op2_q;
    opValid_d = opValid_q;
    if (!stall) begin
      op1_d     = value1;
      op2_d     = value2;
      opValid_d = rd_req;
    end
    if (flush) begin
      opValid_d = 1'b0;
    end
  end

  // Operand stage registers; reset drops any held operand
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q     <= '0;
      op2_q     <= '0;
      opValid_q <= 1'b0;
    end else begin
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      opValid_q <= opValid_d;
    end
  end

  assign op1      = op1_q;
  assign op2      = op2_q;
  assign op_valid = opValid_q;

endmodule

// File: tb/tb_simplerisc_reg_file.sv
// Directed self-checking bench for simplerisc_reg_file.
// Expectations follow SIMPLERISC_RF_BYPASS_EN when it is defined.
module tb_simplerisc_reg_file;

  logic        clk;
  logic        rst;
  logic [3:0]  reg1;
  logic [31:0] writeData;
  logic        writeEnable;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic        rd_req;
  logic        stall;
  logic        flush;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        op_valid;
  logic [31:0] ra_value;

  int total = 0;
  int bad   = 0;

`ifdef SIMPLERISC_RF_BYPASS_EN
  localparam logic [31:0] HAZARD_EXP = 32'h1234_5678;
`else
  localparam logic [31:0] HAZARD_EXP = 32'h0000_0011;
`endif

  simplerisc_reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .reg1        (reg1),
    .writeData   (writeData),
    .writeEnable (writeEnable),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_req      (rd_req),
    .stall       (stall),
    .flush       (flush),
    .op1         (op1),
    .op2         (op2),
    .op_valid    (op_valid),
    .ra_value    (ra_value)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic setWrite(input logic en, input logic [3:0] a, input logic [31:0] d);
    writeEnable = en;
    reg1        = a;
    writeData   = d;
  endtask

  task automatic setRead(input logic req, input logic [3:0] a1, input logic [3:0] a2);
    rd_req   = req;
    rs1_addr = a1;
    rs2_addr = a2;
  endtask

  // Directed test sequence
  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    setWrite(1'b1, 4'd15, 32'hFFFF_FFFF);
    setRead(1'b1, 4'd0, 4'd0);
    #2;
    applyStimulus();
    rst = 1'b0;
    setWrite(1'b0, 4'd0, 32'h0);
    setRead(1'b0, 4'd0, 4'd0);
    checkOutput("reset_op_valid", {31'b0, op_valid}, 32'd0);
    checkOutput("reset_op1", op1, 32'd0);
    checkOutput("reset_op2", op2, 32'd0);
    checkOutput("reset_ra", ra_value, 32'd0);

    // Sweep all registers after reset
    for (int i = 0; i < 16; i++) begin
      setRead(1'b1, 4'(i), 4'(15 - i));
      applyStimulus();
      checkOutput($sformatf("reset_r%0d", i), op1, 32'd0);
      checkOutput($sformatf("reset_r%0d_p2", 15 - i), op2, 32'd0);
      checkOutput("reset_sweep_valid", {31'b0, op_valid}, 32'd1);
    end

    // Write r3 then read rs1=3, rs2=15
    setRead(1'b0, 4'd0, 4'd0);
    setWrite(1'b1, 4'd3, 32'hDEAD_BEEF);
    applyStimulus();
    checkOutput("rdreq0_valid", {31'b0, op_valid}, 32'd0);
    setWrite(1'b0, 4'd0, 32'h0);
    setRead(1'b1, 4'd3, 4'd15);
    applyStimulus();
    checkOutput("wr_rd_op1", op1, 32'hDEAD_BEEF);
    checkOutput("wr_rd_op2", op2, 32'd0);
    checkOutput("wr_rd_valid", {31'b0, op_valid}, 32'd1);

    // Same-cycle hazard on r5
    setRead(1'b0, 4'd0, 4'd0);
    setWrite(1'b1, 4'd5, 32'h0000_0011);
    applyStimulus();
    setWrite(1'b1, 4'd5, 32'h1234_5678);
    setRead(1'b1, 4'd5, 4'd5);
    applyStimulus();
    checkOutput("hazard_op1", op1, HAZARD_EXP);
    checkOutput("hazard_op2", op2, HAZARD_EXP);
    checkOutput("hazard_ra", ra_value, 32'd0);
    setWrite(1'b0, 4'd0, 32'h0);
    applyStimulus();
    checkOutput("hazard_after_op1", op1, 32'h1234_5678);

    // Stall holds the operand while the array keeps accepting writes
    setRead(1'b0, 4'd0, 4'd0);
    setWrite(1'b1, 4'd7, 32'h0000_000A);
    applyStimulus();
    setWrite(1'b0, 4'd0, 32'h0);
    setRead(1'b1, 4'd7, 4'd3);
    applyStimulus();
    checkOutput("stall_load_op1", op1, 32'h0000_000A);
    stall = 1'b1;
    setWrite(1'b1, 4'd7, 32'h0000_000B);
    setRead(1'b0, 4'd7, 4'd7);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("stall_hold_op1_%0d", i), op1, 32'h0000_000A);
      checkOutput($sformatf("stall_hold_op2_%0d", i), op2, 32'hDEAD_BEEF);
      checkOutput($sformatf("stall_hold_valid_%0d", i), {31'b0, op_valid}, 32'd1);
    end
    stall = 1'b0;
    setWrite(1'b0, 4'd0, 32'h0);
    setRead(1'b1, 4'd7, 4'd7);
    applyStimulus();
    checkOutput("stall_release_op1", op1, 32'h0000_000B);
    checkOutput("stall_release_valid", {31'b0, op_valid}, 32'd1);

    // Flush together with stall kills valid; the write still commits
    stall = 1'b1;
    flush = 1'b1;
    setWrite(1'b1, 4'd9, 32'h0000_0099);
    applyStimulus();
    checkOutput("flush_valid", {31'b0, op_valid}, 32'd0);
    stall = 1'b0;
    flush = 1'b0;
    setWrite(1'b0, 4'd0, 32'h0);
    setRead(1'b1, 4'd9, 4'd9);
    applyStimulus();
    checkOutput("flush_write_op1", op1, 32'h0000_0099);
    checkOutput("flush_write_valid", {31'b0, op_valid}, 32'd1);

    // Reset during a stall with a pending r15 write
    setRead(1'b1, 4'd3, 4'd9);
    applyStimulus();
    checkOutput("pre_rst_op1", op1, 32'hDEAD_BEEF);
    stall = 1'b1;
    rst = 1'b1;
    setWrite(1'b1, 4'd15, 32'h0000_0040);
    applyStimulus();
    checkOutput("rst_mid_op1", op1, 32'd0);
    checkOutput("rst_mid_valid", {31'b0, op_valid}, 32'd0);
    checkOutput("rst_mid_ra", ra_value, 32'd0);
    rst = 1'b0;
    stall = 1'b0;
    setRead(1'b0, 4'd0, 4'd0);
    applyStimulus();
    checkOutput("ra_after_write", ra_value, 32'h0000_0040);

    // ra_value has no bypass: a pending write is not visible before the edge
    setWrite(1'b1, 4'd15, 32'h0000_0077);
    #1;
    checkOutput("ra_no_bypass", ra_value, 32'h0000_0040);
    applyStimulus();
    checkOutput("ra_updated", ra_value, 32'h0000_0077);
    setWrite(1'b0, 4'd0, 32'h0);
    setRead(1'b1, 4'd3, 4'd15);
    applyStimulus();
    checkOutput("rst_cleared_r3", op1, 32'd0);
    checkOutput("read_r15_op2", op2, 32'h0000_0077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
